// File: rtl/memory_stage_be_pkg.sv
// Shared definitions for the MEM-stage block: access-size encodings, load FSM
// states, lane count and the sub-word load extraction helper.
package mem_stage_pkg;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11   // behaves as a word access
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } ld_state_e;

   // Pick the addressed byte/half out of a little-endian word and extend it.
   function automatic logic [31:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input mem_size_e   size,
                                               input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b   = word[{lo, 3'b000} +: 8];
      h   = lo[1] ? word[31:16] : word[15:0];
      res = word;
      case (size)
         MEM_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
         MEM_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default:  res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/memory_stage_be_if.sv
// Pipeline-side bus of the MEM stage: EX/MEM request fields, WB forwarding
// data, and the load result / stall / misalign outputs.
interface memory_stage_be_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic [ADDRESS_WIDTH-1:0] i_ALUOutM;
   logic [DATA_WIDTH-1:0]    i_WriteDataM;
   logic [DATA_WIDTH-1:0]    i_ReadDataW;
   logic                     i_MemDataSelM;
   logic                     i_MemReadM;
   logic                     i_MemWriteM;
   logic [1:0]               i_MemSizeM;
   logic                     i_MemUnsignedM;
   logic [DATA_WIDTH-1:0]    o_ReadDataM;
   logic                     o_StallM;
   logic                     o_MisalignM;

   modport master (
      output i_ALUOutM, i_WriteDataM, i_ReadDataW, i_MemDataSelM,
             i_MemReadM, i_MemWriteM, i_MemSizeM, i_MemUnsignedM,
      input  o_ReadDataM, o_StallM, o_MisalignM
   );

   modport slave (
      input  i_ALUOutM, i_WriteDataM, i_ReadDataW, i_MemDataSelM,
             i_MemReadM, i_MemWriteM, i_MemSizeM, i_MemUnsignedM,
      output o_ReadDataM, o_StallM, o_MisalignM
   );
endinterface

// File: rtl/memory_stage_be_data_mem_be.sv
// Word-organised data array with per-byte write enables. Writes land on the
// rising edge; the read port is combinational. Contents are not reset.
module data_mem_be
   import mem_stage_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic               i_CLK,
   input  logic               i_WE,
   input  logic [LANES-1:0]   i_BE,
   input  logic [IDX_W-1:0]   i_WADDR,
   input  logic [31:0]        i_WDATA,
   input  logic [IDX_W-1:0]   i_RADDR,
   output logic [31:0]        o_RDATA
);
   logic [31:0] r_mem [MEM_DEPTH];

   // Byte-lane write.
   always_ff @(posedge i_CLK) begin
      if (i_WE) begin
         for (int k = 0; k < LANES; k++) begin
            if (i_BE[k]) r_mem[i_WADDR][8*k +: 8] <= i_WDATA[8*k +: 8];
         end
      end
   end

   assign o_RDATA = r_mem[i_RADDR];
endmodule

// File: rtl/memory_stage_be.sv
// MEM stage with byte/half/word stores, sign/zero-extended sub-word loads and
// a multi-cycle load pipeline that stalls the hazard unit.
// Optional build macro: MISALIGN_TRAP_EN (flag and suppress misaligned half/word
// accesses); when undefined, low address bits are masked to the access size.
//
// state | meaning
// IDLE  | no load in flight; a load request launches and stalls this cycle
// BUSY  | waiting out the array latency; stall held
// RESP  | o_ReadDataM carries the new load result; stall released
//
// Stall is high for MEM_LATENCY+1 cycles per load (launch cycle plus
// MEM_LATENCY BUSY cycles); the load leaves M at the end of RESP.
module memory_stage_be
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_DEPTH     = 1024,
   parameter int MEM_LATENCY   = 2
) (
   input  logic              i_CLK,
   input  logic              i_RST_n,
   memory_stage_be_if.slave  bus
);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

   ld_state_e        r_state;
   logic [2:0]       r_cnt;
   logic [31:0]      r_rdata;
   logic [IDX_W-1:0] r_idx;
   logic [1:0]       r_lo;
   mem_size_e        r_size;
   logic             r_uns;

   mem_size_e        w_size;
   logic [1:0]       w_lo;
   logic [IDX_W-1:0] w_idx;
   logic             w_trap;
   logic [31:0]      w_wdata_raw;
   logic [31:0]      w_wdata;
   logic [LANES-1:0] w_be;
   logic             w_we;
   logic             w_launch;
   logic [31:0]      w_mem_rdata;

   assign w_size = mem_size_e'(bus.i_MemSizeM);
   assign w_idx  = bus.i_ALUOutM[IDX_W+1:2];

`ifdef MISALIGN_TRAP_EN
   logic w_misaligned;
   assign w_misaligned = ((w_size == MEM_HALF) && bus.i_ALUOutM[0]) ||
                         ((w_size == MEM_WORD || w_size == MEM_RSVD) &&
                          (bus.i_ALUOutM[1:0] != 2'b00));
   assign w_trap = w_misaligned && (bus.i_MemReadM || bus.i_MemWriteM);
`else
   assign w_trap = 1'b0;
`endif

   // Byte offset forced to the natural alignment of the access size.
   always_comb begin
      w_lo = bus.i_ALUOutM[1:0];
      case (w_size)
         MEM_BYTE: w_lo = bus.i_ALUOutM[1:0];
         MEM_HALF: w_lo = {bus.i_ALUOutM[1], 1'b0};
         default:  w_lo = 2'b00;
      endcase
   end

   assign w_wdata_raw = bus.i_MemDataSelM ? bus.i_ReadDataW : bus.i_WriteDataM;

   // Lane replication and byte enables for the store.
   always_comb begin
      w_wdata = w_wdata_raw;
      w_be    = 4'b1111;
      case (w_size)
         MEM_BYTE: begin
            w_wdata = {4{w_wdata_raw[7:0]}};
            w_be    = 4'b0001 << w_lo;
         end
         MEM_HALF: begin
            w_wdata = {2{w_wdata_raw[15:0]}};
            w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_wdata = w_wdata_raw;
            w_be    = 4'b1111;
         end
      endcase
   end

   assign w_we     = bus.i_MemWriteM && !w_trap;
   assign w_launch = (r_state == ST_IDLE) && bus.i_MemReadM && !bus.i_MemWriteM && !w_trap;

   data_mem_be #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_data_mem (
      .i_CLK   (i_CLK),
      .i_WE    (w_we),
      .i_BE    (w_be),
      .i_WADDR (w_idx),
      .i_WDATA (w_wdata),
      .i_RADDR (r_idx),
      .o_RDATA (w_mem_rdata)
   );

   // Load FSM: latch request, count down the latency, register the result.
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_rdata <= 32'h0;
         r_idx   <= '0;
         r_lo    <= 2'b00;
         r_size  <= MEM_BYTE;
         r_uns   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_launch) begin
                  r_idx   <= w_idx;
                  r_lo    <= w_lo;
                  r_size  <= w_size;
                  r_uns   <= bus.i_MemUnsignedM;
                  r_cnt   <= CNT_INIT;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else begin
                  r_rdata <= extend_load(w_mem_rdata, r_lo, r_size, r_uns);
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Reset gating lets the stall drop as soon as reset asserts.
   assign bus.o_StallM    = i_RST_n && (w_launch || (r_state == ST_BUSY));
   assign bus.o_ReadDataM = r_rdata;
   assign bus.o_MisalignM = w_trap;
endmodule

// File: tb/tb_memory_stage_be.sv
module tb_memory_stage_be;
   localparam int L = 2;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memory_stage_be_if bus_if ();

   memory_stage_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_DEPTH(1024), .MEM_LATENCY(L)) dut (
      .i_CLK   (clk),
      .i_RST_n (rst_n),
      .bus     (bus_if)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: byte-addressed 4 KiB image (1024 words) plus expected outputs.
   logic [7:0]  mb [4096];
   logic [31:0] exp_rdata = 32'h0;
   logic        exp_stall = 1'b0;
   logic        exp_mis   = 1'b0;
   bit          chk_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Cycle-by-cycle output comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall",    {31'b0, bus_if.o_StallM},    {31'b0, exp_stall});
         check("rdata",    bus_if.o_ReadDataM,          exp_rdata);
         check("misalign", {31'b0, bus_if.o_MisalignM}, {31'b0, exp_mis});
      end
   end

   function automatic int eff_addr(input logic [31:0] a, input logic [1:0] sz);
      int base;
      base = int'(a[11:0]);
      if (sz == 2'd1) return base - (base % 2);
      if (sz >= 2'd2) return base - (base % 4);
      return base;
   endfunction

   function automatic bit model_mis(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz);
      if (!TRAP || !(rd || wr)) return 1'b0;
      if (sz == 2'd1) return a[0];
      if (sz >= 2'd2) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
      int e;
      int v;
      e = eff_addr(a, sz);
      if (sz == 2'd0) begin
         v = int'(mb[e]);
         if (!uns && v >= 128) v = v - 256;
         return 32'(v);
      end else if (sz == 2'd1) begin
         v = int'(mb[e]) + 256 * int'(mb[e+1]);
         if (!uns && v >= 32768) v = v - 65536;
         return 32'(v);
      end
      return {mb[e+3], mb[e+2], mb[e+1], mb[e]};
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int e;
      int n;
      e = eff_addr(a, sz);
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) mb[e+k] = d[8*k +: 8];
   endtask

   // One M-stage instruction; holds inputs for as long as the stage is stalled.
   task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                     input bit uns, input bit sel, input logic [31:0] wd, input logic [31:0] fwd,
                     output logic [31:0] got, output int scnt);
      bit mis;
      logic [31:0] ld;
      mis  = model_mis(rd, wr, a, sz);
      scnt = 0;
      @(posedge clk); #1;
      bus_if.i_MemReadM     = rd;
      bus_if.i_MemWriteM    = wr;
      bus_if.i_ALUOutM      = a;
      bus_if.i_MemSizeM     = sz;
      bus_if.i_MemUnsignedM = uns;
      bus_if.i_MemDataSelM  = sel;
      bus_if.i_WriteDataM   = wd;
      bus_if.i_ReadDataW    = fwd;
      exp_mis = mis;
      if (rd && !wr && !mis) begin
         ld = model_load(a, sz, uns);
         for (int k = 0; k <= L; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_stall = 1'b1;
            @(negedge clk); #1;
            if (bus_if.o_StallM) scnt++;
         end
         @(posedge clk); #1;
         exp_stall = 1'b0;
         exp_rdata = ld;
         @(negedge clk); #1;
      end else begin
         exp_stall = 1'b0;
         @(negedge clk); #1;
         if (bus_if.o_StallM) scnt++;
         if (wr && !mis) model_store(a, sz, sel ? fwd : wd);
      end
      got = bus_if.o_ReadDataM;
   endtask

   task automatic sw(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] g;
      int s;
      op(1'b0, 1'b1, a, sz, 1'b0, 1'b0, d, 32'h0, g, s);
   endtask

   task automatic ld_chk(input string name, input logic [31:0] a, input logic [1:0] sz,
                         input bit uns, input logic [31:0] req);
      logic [31:0] g;
      int s;
      op(1'b1, 1'b0, a, sz, uns, 1'b0, 32'h0, 32'h0, g, s);
      check(name, g, req);
   endtask

   initial begin
      logic [31:0] g;
      int s;
      bus_if.i_MemReadM     = 1'b0;
      bus_if.i_MemWriteM    = 1'b0;
      bus_if.i_ALUOutM      = 32'h0;
      bus_if.i_MemSizeM     = 2'd2;
      bus_if.i_MemUnsignedM = 1'b0;
      bus_if.i_MemDataSelM  = 1'b0;
      bus_if.i_WriteDataM   = 32'h0;
      bus_if.i_ReadDataW    = 32'h0;
      #12;
      check("reset_stall",    {31'b0, bus_if.o_StallM},    32'h0);
      check("reset_rdata",    bus_if.o_ReadDataM,          32'h0);
      check("reset_misalign", {31'b0, bus_if.o_MisalignM}, 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      for (int i = 0; i < 1024; i++) sw(32'(i * 4), 2'd2, 32'h0);

      // 1: word store/load, stall length
      sw(32'h10, 2'd2, 32'hDEADBEEF);
      op(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, g, s);
      check("t1_lw", g, 32'hDEADBEEF);
      check("t1_stall_cycles", 32'(s), 32'(L + 1));
      // 2: byte stores and signed/unsigned byte loads
      sw(32'h13, 2'd0, 32'h0000007F);
      ld_chk("t2_lb_7f", 32'h13, 2'd0, 1'b0, 32'h0000007F);
      sw(32'h12, 2'd0, 32'h00000080);
      ld_chk("t2_lb_80",  32'h12, 2'd0, 1'b0, 32'hFFFFFF80);
      ld_chk("t2_lbu_80", 32'h12, 2'd0, 1'b1, 32'h00000080);
      // 3: halfword
      sw(32'h22, 2'd1, 32'h00008001);
      ld_chk("t3_lh",  32'h22, 2'd1, 1'b0, 32'hFFFF8001);
      ld_chk("t3_lhu", 32'h22, 2'd1, 1'b1, 32'h00008001);
      ld_chk("t3_lw",  32'h20, 2'd2, 1'b0, 32'h80010000);
      // 4: WB forwarding select
      op(1'b0, 1'b1, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0, 32'h12345678, g, s);
      ld_chk("t4_fwd", 32'h0, 2'd2, 1'b0, 32'h12345678);
      // 5: reset in BUSY
      @(posedge clk); #1;
      bus_if.i_MemReadM  = 1'b1;
      bus_if.i_MemWriteM = 1'b0;
      bus_if.i_ALUOutM   = 32'h10;
      bus_if.i_MemSizeM  = 2'd2;
      exp_mis   = 1'b0;
      exp_stall = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("t5_rst_stall", {31'b0, bus_if.o_StallM}, 32'h0);
      check("t5_rst_rdata", bus_if.o_ReadDataM, 32'h0);
      exp_rdata = 32'h0;
      exp_stall = 1'b0;
      bus_if.i_MemReadM = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      ld_chk("t5_after_rst", 32'h10, 2'd2, 1'b0, 32'h7F80BEEF);
      // 6: misaligned word load
      op(1'b1, 1'b0, 32'h11, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, g, s);
      if (TRAP) begin
         check("t6_trap_nostall", 32'(s), 32'h0);
         check("t6_trap_rdata", g, 32'h7F80BEEF);
      end else begin
         check("t6_mask_rdata", g, 32'h7F80BEEF);
         check("t6_mask_stall", 32'(s), 32'(L + 1));
      end

      // Randomised mix, upper address bits exercise wrap-around.
      for (int n = 0; n < 400; n++) begin
         int r;
         bit rd;
         bit wr;
         logic [31:0] a;
         r  = int'($urandom_range(0, 9));
         rd = (r <= 3) || (r == 7);
         wr = (r >= 4 && r <= 7);
         a  = {$urandom, 12'h0} | 32'($urandom_range(0, 63));
         op(rd, wr, a, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            $urandom, $urandom, g, s);
      end

      @(posedge clk); #1;
      bus_if.i_MemReadM  = 1'b0;
      bus_if.i_MemWriteM = 1'b0;
      exp_stall = 1'b0;
      exp_mis   = 1'b0;
      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
